// File: rtl/irq_enc_pkg.sv
// Shared types and sizes for the interrupt pending encoder.
package irq_enc_pkg;
  localparam int NUM_REQ = 8;
  localparam int CODE_W  = $clog2(NUM_REQ);

  typedef enum logic {IDLE, PRESENT} state_t;
  typedef logic [NUM_REQ-1:0] req_vec_t;
endpackage

// File: rtl/prio_enc_8x3.sv
// Combinational highest-index priority encoder: 8-bit vector to 3-bit code plus any flag.
module prio_enc_8x3
  import irq_enc_pkg::*;
(
  input  logic [7:0] vec,
  output logic [2:0] code,
  output logic       any
);

  always_comb begin
    code = '0;
    any  = |vec;
    // Ascending scan so the highest set index is the last one written.
    for (int k = 0; k < NUM_REQ; k++) begin
      if (vec[k]) code = CODE_W'(k);
    end
  end

endmodule

// File: rtl/irq_pending_encoder.sv
// Request capture into a pending register, highest-index selection, registered code under valid/ready.
// Optional IRQ_ENC_EDGE_EN: only 0->1 transitions of req_i set pending bits.
//
// state   | meaning
// IDLE    | valid_o low, waiting for an unmasked pending request
// PRESENT | valid_o high, code_o frozen until the consumer accepts it
module irq_pending_encoder
  import irq_enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_i,
  input  logic [7:0] mask_i,
  input  logic       ready_i,
  output logic [2:0] code_o,
  output logic       valid_o,
  output logic [7:0] pend_o
);

  state_t   state, state_d;
  req_vec_t pend, set_vec, clr_vec, cand;
  logic [2:0] sel_code, code_d;
  logic       sel_any, valid_d, handshake;

`ifdef IRQ_ENC_EDGE_EN
  req_vec_t req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_q <= '0;
    else     req_q <= req_i;
  end

  assign set_vec = req_i & ~req_q;
`else
  assign set_vec = req_i;
`endif

  assign handshake = valid_o && ready_i;
  assign clr_vec   = handshake ? (req_vec_t'(1) << code_o) : '0;
  assign cand      = pend & ~mask_i;

  prio_enc_8x3 u_prio (
    .vec  (cand),
    .code (sel_code),
    .any  (sel_any)
  );

  // Set is OR-ed after the clear so a same-edge set/clear leaves the bit pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      code_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      state   <= state_d;
      code_o  <= code_d;
      valid_o <= valid_d;
    end
  end

  always_comb begin
    state_d = state;
    code_d  = code_o;
    valid_d = valid_o;
    case (state)
      IDLE: begin
        if (sel_any) begin
          code_d  = sel_code;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  assign pend_o = pend;

endmodule

// File: tb/tb_irq_pending_encoder.sv
// Randomized and directed bench for irq_pending_encoder with a behavioural model and code scoreboard.
module tb_irq_pending_encoder;
  localparam int N = 8;

  logic       clk, rst, ready_i;
  logic [7:0] req_i, mask_i, pend_o;
  logic [2:0] code_o;
  logic       valid_o;

  irq_pending_encoder dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_i),
    .mask_i  (mask_i),
    .ready_i (ready_i),
    .code_o  (code_o),
    .valid_o (valid_o),
    .pend_o  (pend_o)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [7:0] m_pend, m_prev;
  logic       m_valid;
  logic [2:0] m_code;
  int         exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Model: pending set of request indices; one code offered at a time, highest unmasked index first.
  initial begin
    logic [7:0] old_pend, qual;
    logic       found;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pend  = '0;
        m_prev  = '0;
        m_valid = 1'b0;
        m_code  = '0;
        exp_q.delete();
      end else begin
        old_pend = m_pend;
`ifdef IRQ_ENC_EDGE_EN
        qual = req_i & ~m_prev;
`else
        qual = req_i;
`endif
        for (int k = 0; k < N; k++) begin
          if (m_valid && ready_i && (k == int'(m_code))) m_pend[k] = 1'b0;
          if (qual[k]) m_pend[k] = 1'b1;
        end
        m_prev = req_i;
        if (!m_valid) begin
          found = 1'b0;
          for (int k = N - 1; k >= 0; k--) begin
            if (!found && old_pend[k] && !mask_i[k]) begin
              found   = 1'b1;
              m_valid = 1'b1;
              m_code  = 3'(k);
              exp_q.push_back(k);
            end
          end
        end else if (ready_i) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: compare observable state and pop the scoreboard on every accepted code.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("pend", pend_o, m_pend);
        chk("valid", valid_o, m_valid);
        if (valid_o) begin
          chk("code_hold", code_o, m_code);
          if (ready_i) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL accept_code: got %0d expected none (queue empty) at %0t", code_o, $time);
            end else begin
              e = exp_q.pop_front();
              chk("accept_code", code_o, e);
            end
          end
        end
      end
    end
  end

  initial begin
    int waited;
    rst = 1'b1; req_i = '0; mask_i = '0; ready_i = 1'b0;
    cyc(2);
    chk("rst_code", code_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_pend", pend_o, 0);
    rst = 1'b0;
    cyc(2);

    // single request pulse
    ready_i = 1'b1;
    req_i = 8'h04; cyc(1);
    req_i = 8'h00;
    chk("single_pend", pend_o, 8'h04);
    cyc(1);
    chk("single_valid", valid_o, 1);
    chk("single_code", code_o, 2);
    cyc(1);
    chk("single_clear", pend_o, 8'h00);
    chk("single_drop", valid_o, 0);
    cyc(3);

    // multi-hot burst
    req_i = 8'hFF; cyc(1);
    req_i = 8'h00; cyc(20);
    chk("burst_empty", pend_o, 8'h00);

    // backpressure then simultaneous new request and accept
    ready_i = 1'b0;
    req_i = 8'h10; cyc(1);
    req_i = 8'h00; cyc(10);
    chk("bp_valid", valid_o, 1);
    chk("bp_code", code_o, 4);
    req_i = 8'h80; ready_i = 1'b1; cyc(1);
    req_i = 8'h00; cyc(6);

    // mask
    mask_i = 8'h80;
    req_i = 8'h81; cyc(1);
    req_i = 8'h00; cyc(4);
    chk("mask_pend", pend_o, 8'h80);
    mask_i = 8'h00; cyc(4);
    chk("mask_release", pend_o, 8'h00);

    // held level request: repeats in level mode, once in edge mode
    req_i = 8'h08; cyc(12);
    req_i = 8'h00; cyc(4);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      req_i   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      mask_i  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      ready_i = ($urandom_range(0, 2) != 0);
      cyc(1);
    end
    req_i = '0; mask_i = '0; ready_i = 1'b1;
    cyc(30);

    // asynchronous reset mid-handshake
    ready_i = 1'b0;
    req_i = 8'h20; cyc(1);
    req_i = 8'h00;
    waited = 0;
    while (!valid_o && waited < 10) begin
      cyc(1);
      waited++;
    end
    chk("pre_rst_valid", valid_o, 1);
    chk("pre_rst_code", code_o, 5);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", valid_o, 0);
    chk("async_rst_code", code_o, 0);
    chk("async_rst_pend", pend_o, 0);
    cyc(2);
    rst = 1'b0;
    ready_i = 1'b1;
    cyc(4);
    chk("final_queue", exp_q.size(), 0);
    chk("final_valid", valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
